frame_capture_writer: RTL and testbench
=======================================

// Module: frame_capture_writer
// PURPOSE
// Camera-side write front end for the SDRAM frame store. Counts incoming pixels into frame-relative addresses.
// Rotates writes across a ring of NUM_FRAMES frame slots and buffers address/data pairs in a FIFO.
// The SDRAM arbiter drains the FIFO over a valid/ready handshake.
// Reports the last completed slot to the playback side and supports freezing capture for replay.
// PARAMETERS
// PIX_W       10   pixel data width
// H_RES       640  pixels per line
// V_RES       480  lines per frame
// NUM_FRAMES  4    frame slots in ring (>=2, power of 2)
// ADDR_W      25   SDRAM word address width
// FIFO_DEPTH  16   write-request FIFO entries (power of 2)
// PORTS
// cam_clk      in   1                   clock, all logic
// reset        in   1                   synchronous, active-high reset
// pix_valid    in   1                   pixel strobe
// pix_data     in   PIX_W               pixel value
// frame_start  in   1                   qualifies first pixel of a frame (with pix_valid)
// freeze       in   1                   stop capture at next frame boundary
// wr_valid     out  1                   FIFO head valid
// wr_ready     in   1                   arbiter accepts head
// wr_addr      out  ADDR_W              slot*H_RES*V_RES + pixel index
// wr_data      out  PIX_W               pixel for wr_addr
// last_frame   out  $clog2(NUM_FRAMES)  most recently completed slot
// frames_done  out  16                  completed-frame count, saturating at 16'hFFFF
// resync_cnt   out  8                   early frame_start events, saturating
// overflow     out  1                   sticky: pixel dropped on full FIFO
// frozen       out  1                   high in FROZEN state
// BEHAVIOUR
// - Reset: state=WAIT_SYNC, slot=0, pix_idx=0, FIFO empty.
//   All outputs 0: wr_valid, last_frame, frames_done, resync_cnt, overflow, frozen.
// - FSM WAIT_SYNC: discard pixels until pix_valid&frame_start, then go to CAPTURE.
//   That pixel is written as pix_idx 0 of the current slot.
// - CAPTURE: each pix_valid pushes {addr,data} and increments pix_idx.
//   Pixel at pix_idx==H_RES*V_RES-1 ends the frame:
//   last_frame<=slot, slot<=slot+1 mod NUM_FRAMES, pix_idx<=0, frames_done++.
// - Early frame_start (pix_idx!=0): pixel written at idx 0 of the same slot.
//   resync_cnt++; slot and last_frame unchanged.
// - freeze sampled at frame end: if high, go to FROZEN after last_frame update; no further pushes.
//   The FIFO keeps draining. freeze low in FROZEN returns to WAIT_SYNC with slot unchanged.
// - Address: slot*H_RES*V_RES+pix_idx computed in ADDR_W bits; ring must fit (elaboration assertion).
// - FIFO: push to empty FIFO shows on wr_valid/wr_addr/wr_data the next cycle (1-cycle latency).
//   Head changes only on wr_valid&wr_ready. Outputs stable while wr_valid&!wr_ready.
// - Full: push and pop in the same cycle are both accepted.
//   Push on full without pop drops the pixel, sets overflow, and still advances pix_idx (geometry preserved).
// - Reset mid-frame or mid-drain: FIFO flushed; wr_valid low the cycle after reset is sampled.
// CONFIGURATION
// TEST_PATTERN_EN defined:
//   pix_data ignored; wr_data = pix_idx[PIX_W-1:0] ^ {slot, zeros} (slot in the top bits).
//   Timing, handshakes and addressing are identical.
// Not defined: wr_data = pix_data; no pattern logic synthesised.
// TESTING
// 1. Reset, frame_start+valid, 307200 pixels, wr_ready=1 -> wr_addr 0..307199, last_frame=0, frames_done=1.
// 2. Five full frames -> slots 0,1,2,3,0; 5th frame base addr 0, last_frame=0, frames_done=5.
// 3. wr_ready=0 for 20 pixels -> 16 accepted, overflow=1.
//    Release wr_ready -> exactly 16 ordered writes drain, then resumed pixels.
// 4. frame_start at pix_idx 1000 -> next wr_addr=slot base+0, resync_cnt=1, last_frame unchanged.
// 5. freeze=1 mid-frame 2 -> completes frame, last_frame=1... frozen=1, no pushes.
//    freeze=0 -> waits for frame_start.
// 6. reset asserted with 8 entries queued -> wr_valid=0 next cycle, all counters 0.

Source files
------------

// File: rtl/frame_capture_writer.sv
// Camera-side write front end: counts pixels into a ring of frame slots and queues {addr,data} for the SDRAM arbiter.
// Build macro TEST_PATTERN_EN replaces pixel data with an index/slot pattern; the default build passes pix_data through.
module frame_capture_writer #(
    parameter int PIX_W      = 10,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int NUM_FRAMES = 4,
    parameter int ADDR_W     = 25,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          cam_clk,
    input  logic                          reset,
    input  logic                          pix_valid,
    input  logic [PIX_W-1:0]              pix_data,
    input  logic                          frame_start,
    input  logic                          freeze,
    output logic                          wr_valid,
    input  logic                          wr_ready,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [PIX_W-1:0]              wr_data,
    output logic [$clog2(NUM_FRAMES)-1:0] last_frame,
    output logic [15:0]                   frames_done,
    output logic [7:0]                    resync_cnt,
    output logic                          overflow,
    output logic                          frozen
);

    localparam int FRAME_PIX = H_RES * V_RES;
    localparam int IDX_W     = $clog2(FRAME_PIX);
    localparam int SLOT_W    = $clog2(NUM_FRAMES);
    localparam int FIFO_AW   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W   = ADDR_W + PIX_W;
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(FRAME_PIX - 1);
    localparam logic [FIFO_AW:0]   FIFO_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

    if (longint'(NUM_FRAMES) * longint'(FRAME_PIX) > (longint'(1) << ADDR_W)) begin : g_ring_too_big
        $error("frame ring does not fit in ADDR_W address bits");
    end
    if (NUM_FRAMES < 2 || (NUM_FRAMES & (NUM_FRAMES - 1)) != 0) begin : g_bad_num_frames
        $error("NUM_FRAMES must be a power of 2 and at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("FIFO_DEPTH must be a power of 2");
    end

    typedef enum logic [1:0] {
        S_WAIT_SYNC,
        S_CAPTURE,
        S_FROZEN
    } state_t;

    state_t              r_state;
    logic [SLOT_W-1:0]   r_slot;
    logic [IDX_W-1:0]    r_pix_idx;
    logic [SLOT_W-1:0]   r_last_frame;
    logic [15:0]         r_frames_done;
    logic [7:0]          r_resync_cnt;
    logic                r_overflow;

    logic [ENTRY_W-1:0]  r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]  r_wr_ptr;
    logic [FIFO_AW-1:0]  r_rd_ptr;
    logic [FIFO_AW:0]    r_count;

    logic                w_push_req;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_early;
    logic [IDX_W-1:0]    w_push_idx;
    logic [ADDR_W-1:0]   w_base;
    logic [ADDR_W-1:0]   w_push_addr;
    logic [PIX_W-1:0]    w_push_data;

    // A frame_start pixel always lands on index 0, whether it opens a frame or resynchronises one.
    assign w_push_req  = pix_valid && ((r_state == S_WAIT_SYNC && frame_start) || r_state == S_CAPTURE);
    assign w_push_idx  = frame_start ? '0 : r_pix_idx;
    assign w_early     = frame_start && (r_pix_idx != '0);
    assign w_base      = ADDR_W'(r_slot) * ADDR_W'(FRAME_PIX);
    assign w_push_addr = w_base + ADDR_W'(w_push_idx);

`ifdef TEST_PATTERN_EN
    logic [ADDR_W-1:0] w_idx_wide;
    assign w_idx_wide  = ADDR_W'(w_push_idx);
    assign w_push_data = w_idx_wide[PIX_W-1:0] ^ {r_slot, {(PIX_W - SLOT_W){1'b0}}};
`else
    assign w_push_data = pix_data;
`endif

    assign w_full   = (r_count == FIFO_FULL);
    assign wr_valid = (r_count != '0);
    assign w_pop    = wr_valid && wr_ready;
    // On a full FIFO a simultaneous pop frees the slot this push needs.
    assign w_push   = w_push_req && (!w_full || w_pop);

    assign {wr_addr, wr_data} = r_mem[r_rd_ptr];

    // NOTE: storage has no reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge cam_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_push_addr, w_push_data};
        end
    end

    always_ff @(posedge cam_clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (FIFO_AW + 1)'(1);
                2'b01:   r_count <= r_count - (FIFO_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: every state register uses <= so all of them see pre-edge values of each other.
    always_ff @(posedge cam_clk) begin
        if (reset) begin
            r_state       <= S_WAIT_SYNC;
            r_slot        <= '0;
            r_pix_idx     <= '0;
            r_last_frame  <= '0;
            r_frames_done <= '0;
            r_resync_cnt  <= '0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_push_req && !w_push) r_overflow <= 1'b1;

            case (r_state)
                S_WAIT_SYNC: begin
                    if (pix_valid && frame_start) begin
                        r_pix_idx <= IDX_W'(1);
                        r_state   <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (pix_valid) begin
                        if (w_early) begin
                            r_pix_idx <= IDX_W'(1);
                            if (r_resync_cnt != '1) r_resync_cnt <= r_resync_cnt + 8'd1;
                        end else if (w_push_idx == LAST_IDX) begin
                            r_last_frame <= r_slot;
                            r_slot       <= r_slot + SLOT_W'(1);
                            r_pix_idx    <= '0;
                            if (r_frames_done != '1) r_frames_done <= r_frames_done + 16'd1;
                            if (freeze) r_state <= S_FROZEN;
                        end else begin
                            r_pix_idx <= w_push_idx + IDX_W'(1);
                        end
                    end
                end
                S_FROZEN: begin
                    if (!freeze) r_state <= S_WAIT_SYNC;
                end
                default: r_state <= S_WAIT_SYNC;
            endcase
        end
    end

    assign last_frame  = r_last_frame;
    assign frames_done = r_frames_done;
    assign resync_cnt  = r_resync_cnt;
    assign overflow    = r_overflow;
    assign frozen      = (r_state == S_FROZEN);

endmodule

// File: tb/tb_frame_capture_writer.sv
// Scoreboard bench for frame_capture_writer using a small 8x4 frame so full rings fit in a short run.
module tb_frame_capture_writer;

    localparam int PIX_W      = 10;
    localparam int H_RES      = 8;
    localparam int V_RES      = 4;
    localparam int NUM_FRAMES = 4;
    localparam int ADDR_W     = 25;
    localparam int FIFO_DEPTH = 16;
    localparam int FRAME_PIX  = H_RES * V_RES;
    localparam int SLOT_W     = $clog2(NUM_FRAMES);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [PIX_W-1:0]  data;
    } wr_t;

    logic              cam_clk;
    logic              reset;
    logic              pix_valid;
    logic [PIX_W-1:0]  pix_data;
    logic              frame_start;
    logic              freeze;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic [SLOT_W-1:0] last_frame;
    logic [15:0]       frames_done;
    logic [7:0]        resync_cnt;
    logic              overflow;
    logic              frozen;

    frame_capture_writer #(
        .PIX_W(PIX_W), .H_RES(H_RES), .V_RES(V_RES),
        .NUM_FRAMES(NUM_FRAMES), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .cam_clk(cam_clk), .reset(reset), .pix_valid(pix_valid), .pix_data(pix_data),
        .frame_start(frame_start), .freeze(freeze), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .last_frame(last_frame), .frames_done(frames_done),
        .resync_cnt(resync_cnt), .overflow(overflow), .frozen(frozen)
    );

    wr_t sb[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  n_pops   = 0;

    // Reference model state: 0 = waiting for sync, 1 = capturing, 2 = frozen
    int  m_state, m_slot, m_idx;

    bit  ready_en  = 1'b0;
    bit  ready_gap = 1'b0;
    int  cyc = 0;
    bit  prev_stall = 1'b0;
    wr_t prev_head;

    initial cam_clk = 1'b0;
    always #5 cam_clk = ~cam_clk;

    always @(posedge cam_clk) cyc <= cyc + 1;
    assign wr_ready = ready_en && !(ready_gap && (cyc % 4 == 3));

    always @(negedge cam_clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_checks++;
                if (wr_valid !== 1'b1 || {wr_addr, wr_data} !== prev_head) begin
                    n_errors++;
                    $display("FAIL stall_hold: got valid=%b addr=%0d data=%0h, held addr=%0d data=%0h",
                             wr_valid, wr_addr, wr_data, prev_head.addr, prev_head.data);
                end
            end
            if (wr_valid === 1'b1 && wr_ready) begin
                n_checks++;
                n_pops++;
                if (sb.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_write: got addr=%0d data=%0h, expected no write", wr_addr, wr_data);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    if ({wr_addr, wr_data} !== e) begin
                        n_errors++;
                        $display("FAIL write_order: got addr=%0d data=%0h, expected addr=%0d data=%0h",
                                 wr_addr, wr_data, e.addr, e.data);
                    end
                end
            end
            prev_stall = (wr_valid === 1'b1) && !wr_ready;
            prev_head  = {wr_addr, wr_data};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_state = 0;
        m_slot  = 0;
        m_idx   = 0;
        sb.delete();
    endtask

    task automatic idle(input int n);
        pix_valid   = 1'b0;
        frame_start = 1'b0;
        repeat (n) begin
            @(posedge cam_clk);
            #1;
        end
    endtask

    task automatic drive_pix(input logic fs, input bit drop);
        int  push_idx;
        wr_t e;
        pix_valid   = 1'b1;
        frame_start = fs;
        pix_data    = PIX_W'($urandom);
        if (m_state == 1 || (m_state == 0 && fs)) begin
            push_idx = fs ? 0 : m_idx;
            e.addr   = ADDR_W'(m_slot * FRAME_PIX + push_idx);
`ifdef TEST_PATTERN_EN
            e.data   = PIX_W'(push_idx) ^ PIX_W'(m_slot << (PIX_W - SLOT_W));
`else
            e.data   = pix_data;
`endif
            if (!drop) sb.push_back(e);
            if (push_idx == FRAME_PIX - 1) begin
                m_slot = (m_slot + 1) % NUM_FRAMES;
                m_idx  = 0;
                if (freeze) m_state = 2;
            end else begin
                m_idx   = push_idx + 1;
                m_state = 1;
            end
        end
        @(posedge cam_clk);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 400; i++) begin
            if (sb.size() == 0 && wr_valid === 1'b0) break;
            @(posedge cam_clk);
            #1;
        end
        n_checks++;
        if (sb.size() != 0 || wr_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_drain: %0d writes still expected, wr_valid=%b, required 0 and 0", tag, sb.size(), wr_valid);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({wr_valid, last_frame, frames_done, resync_cnt, overflow, frozen} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: valid=%b last=%0d done=%0d resync=%0d ovf=%b frozen=%b, required all 0",
                     wr_valid, last_frame, frames_done, resync_cnt, overflow, frozen);
        end
        for (int i = 0; i < 3; i++) drive_pix(1'b0, 1'b0);
        idle(3);
        n_checks++;
        if (wr_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL wait_sync_discard: wr_valid=%b, required 0", wr_valid);
        end
    endtask

    task automatic test_single_frame();
        for (int i = 0; i < FRAME_PIX; i++) drive_pix(i == 0, 1'b0);
        idle(1);
        wait_drain("single_frame");
        n_checks++;
        if (last_frame !== 2'd0 || frames_done !== 16'd1) begin
            n_errors++;
            $display("FAIL single_frame_status: last=%0d done=%0d, required last=0 done=1", last_frame, frames_done);
        end
    endtask

    task automatic test_ring();
        ready_gap = 1'b1;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < FRAME_PIX; i++) begin
                drive_pix(i == 0, 1'b0);
                idle(1);
            end
        end
        wait_drain("ring");
        ready_gap = 1'b0;
        n_checks++;
        if (last_frame !== 2'd0 || frames_done !== 16'd5) begin
            n_errors++;
            $display("FAIL ring_status: last=%0d done=%0d, required last=0 done=5", last_frame, frames_done);
        end
    endtask

    task automatic test_overflow();
        int p0;
        n_checks++;
        if (overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL overflow_pre: overflow=%b, required 0", overflow);
        end
        ready_en = 1'b0;
        for (int i = 0; i < 20; i++) drive_pix(i == 0, i >= FIFO_DEPTH);
        pix_valid = 1'b0;
        n_checks++;
        if (overflow !== 1'b1 || wr_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL overflow_set: overflow=%b valid=%b, required 1 and 1", overflow, wr_valid);
        end
        p0 = n_pops;
        ready_en = 1'b1;
        for (int i = 20; i < FRAME_PIX; i++) drive_pix(1'b0, 1'b0);
        idle(1);
        wait_drain("overflow");
        n_checks++;
        if (n_pops - p0 != FIFO_DEPTH + FRAME_PIX - 20) begin
            n_errors++;
            $display("FAIL overflow_drain_count: got %0d writes, required %0d", n_pops - p0, FIFO_DEPTH + FRAME_PIX - 20);
        end
        n_checks++;
        if (overflow !== 1'b1 || last_frame !== 2'd1 || frames_done !== 16'd6) begin
            n_errors++;
            $display("FAIL overflow_status: ovf=%b last=%0d done=%0d, required ovf=1 last=1 done=6",
                     overflow, last_frame, frames_done);
        end
    endtask

    task automatic test_resync();
        for (int i = 0; i < 10; i++) drive_pix(i == 0, 1'b0);
        drive_pix(1'b1, 1'b0);
        n_checks++;
        if (resync_cnt !== 8'd1 || last_frame !== 2'd1 || frames_done !== 16'd6) begin
            n_errors++;
            $display("FAIL resync_event: resync=%0d last=%0d done=%0d, required resync=1 last=1 done=6",
                     resync_cnt, last_frame, frames_done);
        end
        for (int i = 1; i < FRAME_PIX; i++) drive_pix(1'b0, 1'b0);
        idle(1);
        wait_drain("resync");
        n_checks++;
        if (resync_cnt !== 8'd1 || last_frame !== 2'd2 || frames_done !== 16'd7) begin
            n_errors++;
            $display("FAIL resync_frame_end: resync=%0d last=%0d done=%0d, required resync=1 last=2 done=7",
                     resync_cnt, last_frame, frames_done);
        end
    endtask

    task automatic test_freeze();
        for (int i = 0; i < FRAME_PIX / 2; i++) drive_pix(i == 0, 1'b0);
        freeze = 1'b1;
        for (int i = FRAME_PIX / 2; i < FRAME_PIX; i++) drive_pix(1'b0, 1'b0);
        n_checks++;
        if (frozen !== 1'b1 || last_frame !== 2'd3 || frames_done !== 16'd8) begin
            n_errors++;
            $display("FAIL freeze_enter: frozen=%b last=%0d done=%0d, required frozen=1 last=3 done=8",
                     frozen, last_frame, frames_done);
        end
        for (int i = 0; i < 5; i++) drive_pix(i == 0, 1'b0);
        idle(1);
        wait_drain("frozen");
        n_checks++;
        if (frozen !== 1'b1) begin
            n_errors++;
            $display("FAIL freeze_hold: frozen=%b, required 1", frozen);
        end
        freeze = 1'b0;
        idle(1);
        n_checks++;
        if (frozen !== 1'b0) begin
            n_errors++;
            $display("FAIL freeze_release: frozen=%b, required 0", frozen);
        end
        m_state = 0;
        for (int i = 0; i < 2; i++) drive_pix(1'b0, 1'b0);
        idle(2);
        n_checks++;
        if (wr_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL freeze_wait_sync: wr_valid=%b, required 0", wr_valid);
        end
    endtask

    task automatic test_reset_mid_drain();
        ready_en = 1'b0;
        for (int i = 0; i < 8; i++) drive_pix(i == 0, 1'b0);
        idle(1);
        n_checks++;
        if (wr_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL queued_before_reset: wr_valid=%b, required 1", wr_valid);
        end
        reset = 1'b1;
        @(posedge cam_clk);
        #1;
        n_checks++;
        if ({wr_valid, last_frame, frames_done, resync_cnt, overflow, frozen} !== '0) begin
            n_errors++;
            $display("FAIL reset_flush: valid=%b last=%0d done=%0d resync=%0d ovf=%b frozen=%b, required all 0",
                     wr_valid, last_frame, frames_done, resync_cnt, overflow, frozen);
        end
        reset = 1'b0;
        model_reset();
        ready_en = 1'b1;
        for (int i = 0; i < FRAME_PIX; i++) drive_pix(i == 0, 1'b0);
        idle(1);
        wait_drain("post_reset");
        n_checks++;
        if (last_frame !== 2'd0 || frames_done !== 16'd1 || overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset_frame: last=%0d done=%0d ovf=%b, required last=0 done=1 ovf=0",
                     last_frame, frames_done, overflow);
        end
    endtask

    initial begin
        reset       = 1'b1;
        pix_valid   = 1'b0;
        pix_data    = '0;
        frame_start = 1'b0;
        freeze      = 1'b0;
        model_reset();
        repeat (3) @(posedge cam_clk);
        #1;
        reset    = 1'b0;
        ready_en = 1'b1;

        test_reset();
        test_single_frame();
        test_ring();
        test_overflow();
        test_resync();
        test_freeze();
        test_reset_mid_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
